// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame
//   Receive-only PS/2 device-to-host deserializer. Both raw PS/2 lines are
//   synchronized into the clk domain. The PS/2 clock is glitch-filtered, and
//   each falling edge of the filtered clock samples one bit. 11-bit frames
//   (start, 8 data LSB-first, odd parity, stop) are assembled into bytes.
//   A good frame produces a one-cycle received_data_en strobe together with
//   the new byte. A bad frame produces a one-cycle frame_err strobe instead.
//   A frame is bad on a parity error, a stop error or an inter-bit timeout.
//
// Ports
//   clk              system clock
//   reset            synchronous, active-high reset
//   ps2_clk          raw PS/2 clock line (asynchronous)
//   ps2_dat          raw PS/2 data line (asynchronous)
//   received_data    last correctly received byte
//   received_data_en one-cycle pulse: received_data just updated
//   frame_err        one-cycle pulse: parity error, stop error or timeout
//   busy             high while a frame is in progress

module ps2_rx_frame #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] received_data,
    output logic       received_data_en,
    output logic       frame_err,
    output logic       busy
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]      FILT_LAST = 8'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Odd parity: the data bits plus the parity bit must hold an odd
    // number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data,
                                           input logic       par);
        return (^data) ^ par;
    endfunction

    // ------------------------------------------------------------------
    // Stage p0/p1: two-flop synchronizers. They idle high, like the bus.
    // ------------------------------------------------------------------
    logic clk_p0, clk_p1;
    logic dat_p0, dat_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_p0 <= 1'b1;
            clk_p1 <= 1'b1;
            dat_p0 <= 1'b1;
            dat_p1 <= 1'b1;
        end else begin
            clk_p0 <= ps2_clk;
            clk_p1 <= clk_p0;
            dat_p0 <= ps2_dat;
            dat_p1 <= dat_p0;
        end
    end

    // ------------------------------------------------------------------
    // Stage p2: glitch filter on the synchronized PS/2 clock
    // ------------------------------------------------------------------
    logic       filt_clk;
    logic [7:0] filt_cnt;

    // The filtered value changes only after FILTER_LEN consecutive
    // samples disagree with it. Any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_clk <= 1'b1;
            filt_cnt <= 8'd0;
        end else if (clk_p1 != filt_clk) begin
            if (filt_cnt == FILT_LAST) begin
                filt_clk <= clk_p1;
                filt_cnt <= 8'd0;
            end else begin
                filt_cnt <= filt_cnt + 8'd1;
            end
        end else begin
            filt_cnt <= 8'd0;
        end
    end

    // ------------------------------------------------------------------
    // Stage p3: falling-edge strobe of the filtered clock
    // ------------------------------------------------------------------
    logic filt_clk_d;
    logic strobe;

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_clk_d <= 1'b1;
            strobe     <= 1'b0;
        end else begin
            filt_clk_d <= filt_clk;
            strobe     <= filt_clk_d & ~filt_clk;
        end
    end

    // ------------------------------------------------------------------
    // Stage p4: frame FSM, timeout and registered outputs
    // ------------------------------------------------------------------
    state_t          state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            parity_ok;
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            bit_cnt          <= 3'd0;
            shreg            <= 8'h00;
            parity_ok        <= 1'b0;
            to_cnt           <= '0;
            received_data    <= 8'h00;
            received_data_en <= 1'b0;
            frame_err        <= 1'b0;
            busy             <= 1'b0;
        end else begin
            received_data_en <= 1'b0;
            frame_err        <= 1'b0;

            // The counter measures the gap since the last bit strobe
            // inside a frame. It is held at zero while idle.
            if (state == IDLE || strobe) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end

            // A strobe takes priority over a timeout that expires in
            // the same cycle.
            if (strobe) begin
                case (state)
                    IDLE: begin
                        // A high "start" bit is line noise. It is
                        // ignored without raising an error.
                        if (!dat_p1) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                            busy    <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg   <= {dat_p1, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_ok <= odd_parity_ok(shreg, dat_p1);
                        state     <= STOP;
                    end
                    STOP: begin
                        if (dat_p1 && parity_ok) begin
                            received_data    <= shreg;
                            received_data_en <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end else if (state != IDLE && to_cnt == TO_LAST) begin
                frame_err <= 1'b1;
                state     <= IDLE;
                shreg     <= 8'h00;
                bit_cnt   <= 3'd0;
                to_cnt    <= '0;
                busy      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_frame.sv
module tb_ps2_rx_frame;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 5000;
    localparam int LATENCY    = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       frame_err;
    logic       busy;

    ps2_rx_frame #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ps2_clk         (ps2_clk),
        .ps2_dat         (ps2_dat),
        .received_data   (received_data),
        .received_data_en(received_data_en),
        .frame_err       (frame_err),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // lat: 1 = pulse exactly LATENCY cycles after the last raw falling edge,
    //      2 = timeout pulse about TIMEOUT cycles after the last strobe.
    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
        logic [1:0] lat;
    } exp_t;

    exp_t       exp_q[$];
    int         last_fall = 0;
    logic [7:0] last_good = 8'h00;
    logic       en_prev   = 1'b0;
    logic       err_prev  = 1'b0;

    // Scoreboard: each output pulse is matched against the oldest
    // expected event.
    always @(negedge clk) begin
        exp_t e;
        int   delta;
        if (received_data_en === 1'b1 && frame_err === 1'b1)
            chk("en_and_err", 1, 0);
        if (received_data_en === 1'b1 || frame_err === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {frame_err, received_data_en}, 0);
            end else begin
                e     = exp_q.pop_front();
                delta = cyc - last_fall;
                chk("pulse_kind_err", frame_err, e.is_err);
                if (e.is_err) begin
                    chk("err_data_hold", received_data, last_good);
                    chk("err_width", err_prev, 0);
                end else begin
                    chk("rx_data", received_data, e.data);
                    chk("en_width", en_prev, 0);
                    last_good = e.data;
                end
                if (e.lat == 2'd1)
                    chk("latency", delta, LATENCY);
                else if (e.lat == 2'd2)
                    chk("timeout_window",
                        (delta >= TIMEOUT + 11 && delta <= TIMEOUT + 20), 1);
            end
        end
        en_prev  = received_data_en;
        err_prev = frame_err;
    end

    // One PS/2 bit: 500 cycles high with the data changing mid-high,
    // followed by 500 cycles low.
    task automatic ps2_bit(input logic b);
        repeat (250) @(negedge clk);
        ps2_dat = b;
        repeat (250) @(negedge clk);
        ps2_clk   = 1'b0;
        last_fall = cyc;
        repeat (500) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par);
        logic p;
        exp_t e;
        p        = (~^d) ^ bad_par;
        e.is_err = bad_par;
        e.data   = d;
        e.lat    = 2'd1;
        exp_q.push_back(e);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            ps2_bit(d[i]);
            if (i == 4) chk("busy_mid_frame", busy, 1);
        end
        ps2_bit(p);
        ps2_bit(1'b1);
    endtask

    task automatic push_timeout();
        exp_t e;
        e.is_err = 1'b1;
        e.data   = 8'h00;
        e.lat    = 2'd2;
        exp_q.push_back(e);
    endtask

    initial begin
        logic [7:0] b42;
        logic       busy_seen;
        reset   = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_data", received_data, 8'h00);
        chk("rst_en", received_data_en, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        repeat (20) @(negedge clk);

        // Back-to-back frames F0 then 23 (the 23 also covers the single-frame case)
        send_frame(8'hF0, 1'b0);
        send_frame(8'h23, 1'b0);
        repeat (30) @(negedge clk);
        chk("busy_after_23", busy, 0);
        chk("data_23", received_data, 8'h23);

        // Wrong parity on 1E, then a good 16
        send_frame(8'h1E, 1'b1);
        repeat (30) @(negedge clk);
        chk("data_hold_after_bad", received_data, 8'h23);
        send_frame(8'h16, 1'b0);

        // Start + 3 data bits, then the line stays high
        push_timeout();
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        chk("busy_partial", busy, 1);
        repeat (TIMEOUT) @(negedge clk);
        chk("timeout_seen", exp_q.size(), 0);
        chk("busy_after_timeout", busy, 0);
        send_frame(8'h3B, 1'b0);
        repeat (30) @(negedge clk);

        // Idle glitches of 3 and 7 cycles on ps2_clk with data low
        ps2_dat   = 1'b0;
        busy_seen = 1'b0;
        ps2_clk   = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            busy_seen |= busy;
        end
        ps2_clk = 1'b0;
        repeat (7) @(negedge clk);
        ps2_clk = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            busy_seen |= busy;
        end
        chk("glitch_busy", busy_seen, 0);
        ps2_dat = 1'b1;
        repeat (20) @(negedge clk);

        // Reset after the 5th data bit of 42
        b42 = 8'h42;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(b42[i]);
        chk("busy_before_reset", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last_good = 8'h00;
        chk("mid_rst_data", received_data, 8'h00);
        chk("mid_rst_en", received_data_en, 0);
        chk("mid_rst_err", frame_err, 0);
        chk("mid_rst_busy", busy, 0);
        // Remaining bits: d5 = 0 looks like a start bit, so the leftover
        // edges form a short frame that can only end in a timeout.
        push_timeout();
        for (int i = 5; i < 8; i++) ps2_bit(b42[i]);
        ps2_bit(~^b42);
        ps2_bit(1'b1);
        repeat (TIMEOUT) @(negedge clk);
        chk("leftover_timeout", exp_q.size(), 0);
        send_frame(8'h42, 1'b0);

        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("queue_drained", exp_q.size(), 0);
        chk("final_data", received_data, 8'h42);
        chk("final_busy", busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_rx_frame.md
Name: ps2_rx_frame

Overview:
- Receive-only PS/2 device-to-host deserializer.
- Sits directly upstream of the keyboard decoder's raw-byte capture register and drives its received_data / received_data_en interface.
- Synchronizes and glitch-filters the PS/2 clock and data lines, frames 11-bit packets (start, 8 data LSB-first, odd parity, stop), and emits one-cycle strobes for good bytes and bad frames.

Parameters:
FILTER_LEN, 8, consecutive identical synchronized ps2_clk samples required before the filtered clock changes (range 2..255)
TIMEOUT_CYCLES, 50000, max clk cycles between bit strobes inside a frame before abort (1 ms at 50 MHz)

Ports:
clk  input  1  system clock (50 MHz)
reset  input  1  synchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock line (asynchronous)
ps2_dat  input  1  raw PS/2 data line (asynchronous)
received_data  output  8  last correctly received byte
received_data_en  output  1  one-cycle pulse: received_data just updated
frame_err  output  1  one-cycle pulse: parity error, stop error or timeout
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (synchronous, active-high): both 2-flop synchronizers preset to 1; filtered clock = 1; filter count 0; FSM IDLE; bit count 0; shift register 0; timeout count 0; received_data = 8'h00; received_data_en, frame_err and busy = 0. Reset mid-frame discards the partial frame with no error pulse.
- Synchronizers: ps2_clk and ps2_dat each pass through 2 flops before use.
- Filter:
  - Counter increments while synchronized ps2_clk differs from the filtered value, and clears when they match.
  - When the count reaches FILTER_LEN-1 and the sample still differs, the filtered value takes the sample and the count clears.
  - Pulses shorter than FILTER_LEN cycles never reach the FSM.
- Strobe: registered one-cycle pulse in the cycle after the filtered clock goes 1->0. The data bit is the synchronized ps2_dat value in the strobe cycle.
- FSM states IDLE, DATA, PARITY, STOP. Transitions happen only on a strobe, except for timeout.
  - IDLE: strobe with dat=0 -> DATA, bit count 0. Strobe with dat=1 is ignored and raises no error.
  - DATA: shreg <= {dat, shreg[7:1]}, bit count +1. The strobe that shifts in the 8th bit -> PARITY.
  - PARITY: latch the parity bit; parity_ok = (^shreg) ^ parity_bit (odd parity required). -> STOP.
  - STOP, on strobe:
    - If dat=1 and parity_ok: received_data <= shreg and received_data_en = 1, both in the next cycle.
    - Otherwise: frame_err = 1 in the next cycle and received_data holds.
    - Either way -> IDLE.
- Latency: raw stop-bit clock falling edge -> received_data_en is 2 sync + FILTER_LEN filter + 1 strobe + 1 output cycles (12 clk at default).
- Timeout:
  - Counter of width $clog2(TIMEOUT_CYCLES+1) clears on every strobe and in IDLE, and increments otherwise.
  - On reaching TIMEOUT_CYCLES while not IDLE: frame_err pulse next cycle, FSM -> IDLE, shreg and bit count cleared.
  - If a strobe arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the strobe wins and the counter clears.
- received_data_en and frame_err are never high in the same cycle; each lasts exactly 1 cycle.
- Back-to-back frames (e.g. F0 then 23) are accepted with no dead time beyond the stop bit.
- busy goes high in the cycle after the start-bit strobe and goes low in the same cycle as the en/err pulse.
- Bytes are not interpreted (F0/E0 passed through unchanged). The block has no host-to-device transmit path.

Test Plan:
- Bench settings for all scenarios: PS/2 clock period 1000 clk (500 high, 500 low), data changes mid-high, TIMEOUT_CYCLES=5000, FILTER_LEN=8.
1. Frame 0x23 (bits 0,1,1,0,0,0,1,0,0,P=0,1) -> received_data=0x23, received_data_en high exactly 1 cycle, 12 clk after the stop-bit falling edge; frame_err stays 0.
2. Frames 0xF0 then 0x23 back-to-back -> two en pulses, received_data reads 0xF0 then 0x23; busy low between frames only around the stop/start boundary.
3. Frame 0x1E sent with parity bit 0 (wrong; correct is 1) -> frame_err 1-cycle pulse, no en, received_data keeps its previous value; next good frame 0x16 -> en, data 0x16.
4. Start + 3 data bits, then ps2_clk held high -> frame_err pulse 5000 clk after the last strobe, busy=0; a subsequent good 0x3B is received correctly.
5. In IDLE, a 3-cycle low glitch on ps2_clk, then a 7-cycle low glitch -> no strobe, busy stays 0, no en/err pulse.
6. Reset asserted for 1 cycle after the 5th data bit of 0x42 -> all outputs 0 and busy 0 next cycle, no err pulse; the remaining edges of the broken frame cause no en pulse; following frame 0x42 received correctly.
